trigger_latency_monitor: RTL and testbench
==========================================

TRIGGER_LATENCY_MONITOR -- requirements
Module: trigger_latency_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the latency counter and of the reported latency.
REQ-002 Parameter TIMEOUT, default 255: maximum measured latency in cycles; SHALL satisfy 1 <= TIMEOUT <= 2^CNT_W-1.
REQ-003 Parameter DEPTH, default 4: result FIFO depth; SHALL be a power of two, >= 2.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  arm request; a measurement starts on its rising edge; synchronous to clk.
REQ-007 trigger  input  1  response from the downstream edge-wait stage; a measurement ends on its rising edge; synchronous to clk.
REQ-008 clear  input  1  synchronous clear of the sticky flags and counters below.
REQ-009 m_valid  output  1  FIFO head holds a result.
REQ-010 m_ready  input  1  consumer accepts the head.
REQ-011 m_data  output  CNT_W+1  {timeout_flag, latency}.
REQ-012 busy  output  1  a measurement is in progress (state MEASURE).
REQ-013 overflow  output  1  sticky: at least one result was dropped because the FIFO was full.
REQ-014 stray_cnt  output  8  saturating count of trigger rising edges seen in IDLE.

Function
REQ-015 Edge detection SHALL use one register per input holding the previous sampled value; rise = current 1 and previous 0.
REQ-016 The FSM SHALL have exactly two states: IDLE and MEASURE.
REQ-017 IDLE with enable rise SHALL load cnt to 1 and go to MEASURE.
REQ-018 MEASURE with trigger rise SHALL push {0, cnt} and return to IDLE.
REQ-019 Reported latency SHALL equal the cycle index of the first trigger=1 sample minus the cycle index of the first enable=1 sample.
REQ-020 MEASURE with no trigger rise and cnt == TIMEOUT SHALL push {1, TIMEOUT} and return to IDLE.
REQ-021 MEASURE with no trigger rise and cnt < TIMEOUT SHALL increment cnt; cnt SHALL never wrap.
REQ-022 MEASURE with an enable rise and no trigger rise SHALL restart: cnt <= 1, stay in MEASURE, no push.
REQ-023 Enable rise and trigger rise in the same MEASURE cycle SHALL push {0, cnt}, load cnt to 1 and stay in MEASURE.
REQ-024 Enable rise and trigger rise in the same IDLE cycle SHALL start a measurement and SHALL not count as stray.
REQ-025 A trigger rise in IDLE SHALL increment stray_cnt, saturating at 255.
REQ-026 The FIFO SHALL be first-word fall-through: a pushed result appears on m_valid/m_data the cycle after the push.
REQ-027 A pop SHALL occur when m_valid and m_ready are both 1; m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 A push when full with no pop SHALL be dropped, SHALL set overflow, and SHALL leave the FIFO unchanged.
REQ-029 A push and pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-030 clear=1 SHALL zero overflow and stray_cnt at the next edge and SHALL not affect the FSM or the FIFO.
REQ-031 busy SHALL be 1 exactly when the state is MEASURE.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, cnt 0, FIFO empty (m_valid 0), m_data 0, busy 0, overflow 0, stray_cnt 0.
REQ-033 Both edge-history registers SHALL reset to 0, so an input already high at reset release registers as a rise on the first clock.
REQ-034 Reset asserted mid-measurement SHALL abandon the measurement; no result is pushed.

Verification
REQ-035 enable rises cycle 10, trigger rises cycle 15, m_ready=1 -> m_valid pulses one cycle at cycle 16, m_data={0,5}, busy high cycles 11-15.
REQ-036 enable rise, trigger held 0, TIMEOUT=20 -> exactly one result {1,20}; busy returns to 0; no further pushes.
REQ-037 m_ready=0, five completed measurements with DEPTH=4 -> first four retained in order, fifth dropped, overflow=1; clear=1 -> overflow=0, FIFO intact.
REQ-038 enable rises cycle 10, again cycle 13, trigger rises cycle 16 -> single result {0,3}.
REQ-039 In IDLE, trigger pulsed three times -> stray_cnt=3, no results; same-cycle enable+trigger rise in MEASURE -> {0,cnt} pushed and busy stays 1.
REQ-040 rst_n pulsed low mid-MEASURE with a non-empty FIFO -> outputs take their reset values asynchronously; no result appears after release.

Source files
------------

// File: rtl/trigger_latency_monitor.sv
// Trigger latency monitor: measures cycles from an enable rising edge to the
// next trigger rising edge, with timeout, and queues {timeout_flag, latency}
// results in a small first-word fall-through FIFO.
module trigger_latency_monitor #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             trigger,
    input  logic             clear,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W:0]   m_data,
    output logic             busy,
    output logic             overflow,
    output logic [7:0]       stray_cnt
);

    localparam int               AW        = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             en_prev, trig_prev;
    logic             en_rise, trig_rise;
    logic             push, stray_hit;
    logic [CNT_W:0]   push_data;

    logic [CNT_W:0]   mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, pop, do_push;

    // Saturating 8-bit increment for the stray counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign en_rise   = enable  & ~en_prev;
    assign trig_rise = trigger & ~trig_prev;

    // Edge-history registers; reset to 0 so a high input at release reads as a rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_prev   <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            en_prev   <= enable;
            trig_prev <= trigger;
        end
    end

    // FSM state and latency counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: start, restart, completion, timeout and stray detection
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        push       = 1'b0;
        push_data  = '0;
        stray_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (en_rise) begin
                    cnt_next   = CNT_ONE;
                    state_next = MEASURE;
                end else if (trig_rise) begin
                    stray_hit = 1'b1;
                end
            end
            MEASURE: begin
                if (trig_rise) begin
                    push      = 1'b1;
                    push_data = {1'b0, cnt};
                    if (en_rise) begin
                        // Back-to-back: close this measurement and open the next
                        cnt_next = CNT_ONE;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (en_rise) begin
                    cnt_next = CNT_ONE;
                end else if (cnt >= TIMEOUT_C) begin
                    push       = 1'b1;
                    push_data  = {1'b1, TIMEOUT_C};
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = m_valid & m_ready;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle
    assign do_push = push & (~full | pop);

    // FIFO storage; contents are never observed while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky overflow flag and stray-trigger counter, both cleared by clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            stray_cnt <= 8'd0;
        end else if (clear) begin
            overflow  <= 1'b0;
            stray_cnt <= 8'd0;
        end else begin
            if (push && full && !pop) overflow <= 1'b1;
            if (stray_hit)            stray_cnt <= sat_inc8(stray_cnt);
        end
    end

    assign m_valid = ~empty;
    assign m_data  = m_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign busy    = (state == MEASURE);

endmodule

// File: tb/tb_trigger_latency_monitor.sv
// Self-checking bench for trigger_latency_monitor (CNT_W=8, TIMEOUT=20, DEPTH=4).
module tb_trigger_latency_monitor;

    logic       clk = 1'b0;
    logic       rst_n, enable, trigger, clear, m_ready;
    logic       m_valid, busy, overflow;
    logic [8:0] m_data;
    logic [7:0] stray_cnt;

    int total = 0;
    int bad   = 0;

    trigger_latency_monitor #(.CNT_W(8), .TIMEOUT(20), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger),
        .clear(clear), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .overflow(overflow), .stray_cnt(stray_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, trig, clr, rdy;
        logic       exp_valid;
        logic [8:0] exp_data;
        logic       exp_busy, exp_ovf;
        logic [7:0] exp_stray;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One measurement of latency L; rdy_t drives m_ready on the trigger cycle
    task automatic measure(input int L, input logic rdy_t);
        enable = 1'b1; trigger = 1'b0; m_ready = 1'b0;
        tick();
        enable = 1'b0;
        repeat (L - 1) tick();
        trigger = 1'b1; m_ready = rdy_t;
        tick();
        trigger = 1'b0; m_ready = 1'b0;
        tick();
    endtask

    task automatic read_expect(input logic [8:0] exp);
        check("fifo_head_valid", 32'(m_valid), 32'd1);
        check("fifo_head_data", 32'(m_data), 32'(exp));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        int first_k, n_res;
        logic [8:0] res_data;
        logic seen;

        rst_n = 1'b0; enable = 1'b0; trigger = 1'b0; clear = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_stray", 32'(stray_cnt), 32'd0);
        rst_n = 1'b1;

        //           en trig clr rdy  valid data    busy ovf stray
        tbl[0]  = '{0, 0, 0, 1,   0, 9'h000, 0, 0, 8'd0};
        tbl[1]  = '{1, 0, 0, 1,   0, 9'h000, 1, 0, 8'd0};
        tbl[2]  = '{1, 0, 0, 1,   0, 9'h000, 1, 0, 8'd0};
        tbl[3]  = '{0, 0, 0, 1,   0, 9'h000, 1, 0, 8'd0};
        tbl[4]  = '{0, 0, 0, 1,   0, 9'h000, 1, 0, 8'd0};
        tbl[5]  = '{0, 0, 0, 1,   0, 9'h000, 1, 0, 8'd0};
        tbl[6]  = '{0, 1, 0, 1,   1, 9'h005, 0, 0, 8'd0};
        tbl[7]  = '{0, 1, 0, 1,   0, 9'h000, 0, 0, 8'd0};
        tbl[8]  = '{0, 0, 0, 1,   0, 9'h000, 0, 0, 8'd0};
        tbl[9]  = '{0, 1, 0, 1,   0, 9'h000, 0, 0, 8'd1};
        tbl[10] = '{0, 0, 0, 1,   0, 9'h000, 0, 0, 8'd1};
        tbl[11] = '{0, 1, 0, 1,   0, 9'h000, 0, 0, 8'd2};
        tbl[12] = '{0, 0, 1, 1,   0, 9'h000, 0, 0, 8'd0};
        tbl[13] = '{1, 1, 0, 1,   0, 9'h000, 1, 0, 8'd0};
        tbl[14] = '{0, 0, 0, 1,   0, 9'h000, 1, 0, 8'd0};
        tbl[15] = '{1, 1, 0, 0,   1, 9'h002, 1, 0, 8'd0};
        tbl[16] = '{0, 0, 0, 0,   1, 9'h002, 1, 0, 8'd0};
        tbl[17] = '{0, 0, 0, 0,   1, 9'h002, 1, 0, 8'd0};
        tbl[18] = '{0, 1, 0, 0,   1, 9'h002, 0, 0, 8'd0};
        tbl[19] = '{0, 0, 0, 1,   1, 9'h003, 0, 0, 8'd0};
        tbl[20] = '{0, 0, 0, 1,   0, 9'h000, 0, 0, 8'd0};

        for (int i = 0; i < 21; i++) begin
            enable = tbl[i].en; trigger = tbl[i].trig; clear = tbl[i].clr; m_ready = tbl[i].rdy;
            tick();
            check($sformatf("row%0d_valid", i), 32'(m_valid), 32'(tbl[i].exp_valid));
            check($sformatf("row%0d_data", i), 32'(m_data), 32'(tbl[i].exp_data));
            check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            check($sformatf("row%0d_ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
            check($sformatf("row%0d_stray", i), 32'(stray_cnt), 32'(tbl[i].exp_stray));
        end
        enable = 1'b0; trigger = 1'b0; clear = 1'b0; m_ready = 1'b1;

        // Timeout: enable rise with trigger held low yields exactly one {1,20}
        enable = 1'b1;
        tick();
        check("to_busy_start", 32'(busy), 32'd1);
        enable = 1'b0;
        first_k = -1; n_res = 0; res_data = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (m_valid) begin
                n_res++;
                if (first_k < 0) begin
                    first_k = k;
                    res_data = m_data;
                end
            end
        end
        check("to_count", 32'(n_res), 32'd1);
        check("to_cycle", 32'(first_k), 32'd20);
        check("to_data", 32'(res_data), 32'h114);
        check("to_busy_end", 32'(busy), 32'd0);

        // Stray counter saturates at 255, then clear zeroes it
        for (int k = 0; k < 260; k++) begin
            trigger = 1'b1; tick();
            trigger = 1'b0; tick();
        end
        check("stray_sat", 32'(stray_cnt), 32'd255);
        check("stray_no_result", 32'(m_valid), 32'd0);
        clear = 1'b1; tick(); clear = 1'b0;
        check("stray_clear", 32'(stray_cnt), 32'd0);

        // Overflow: five results into a depth-4 FIFO with m_ready low
        for (int L = 1; L <= 4; L++) measure(L, 1'b0);
        check("ovf_before", 32'(overflow), 32'd0);
        measure(5, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);
        for (int L = 1; L <= 4; L++) read_expect(9'(L));
        check("ovf_drained", 32'(m_valid), 32'd0);

        // Push and pop in the same cycle while full both take effect
        for (int L = 1; L <= 4; L++) measure(L, 1'b0);
        measure(6, 1'b1);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        read_expect(9'd2);
        read_expect(9'd3);
        read_expect(9'd4);
        read_expect(9'd6);
        check("fullpp_drained", 32'(m_valid), 32'd0);

        // Asynchronous reset mid-measurement with a non-empty FIFO
        trigger = 1'b1; tick(); trigger = 1'b0; tick();
        measure(3, 1'b0);
        enable = 1'b1; tick(); enable = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_stray", 32'(stray_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_data", 32'(m_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_stray", 32'(stray_cnt), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (m_valid || busy) seen = 1'b1;
        end
        check("arst_no_result", 32'(seen), 32'd0);

        // Enable already high at reset release counts as a rise on the first clock
        rst_n = 1'b0; enable = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("release_rise_busy", 32'(busy), 32'd1);
        enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
